// File: rtl/traffic_pkg.sv
// Shared definitions for the vehicle-light bus and the pedestrian channel FSM.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PED_IDLE,
        PED_ARMED,
        PED_WALK,
        PED_CLEAR
    } ped_state_e;

    // Only an exact one-hot green counts; corrupted encodings are treated as not green.
    function automatic logic is_green(input logic [2:0] light);
        return light == LIGHT_GREEN;
    endfunction

endpackage

// File: rtl/ped_channel.sv
// One crosswalk direction: request latch, WALK/CLEAR sequencing, flashing clearance
// and countdown, slaved to the parallel vehicle green.
module ped_channel
    import traffic_pkg::*;
#(
    parameter int WALK_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 6,
    parameter int FLASH_DIV    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light,
    input  logic       btn,
    output logic       walk,
    output logic       dont_walk,
    output logic [7:0] countdown,
    output logic       abort
);

    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [7:0]    WALK_LOAD  = 8'(WALK_CYCLES - 1);
    localparam logic [7:0]    CLEAR_LOAD = 8'(CLEAR_CYCLES);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_DIV - 1);

    ped_state_e    state, state_nx;
    logic          prev_green;
    logic          req, req_nx;
    logic [7:0]    walk_cnt, walk_cnt_nx;
    logic [FW-1:0] flash_cnt, flash_cnt_nx;
    logic          walk_nx, dont_walk_nx, abort_nx;
    logic [7:0]    countdown_nx;
    logic          green, green_rise, req_held;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        green        = is_green(light);
        green_rise   = green & ~prev_green;
        req_held     = req | btn;
        state_nx     = state;
        req_nx       = req_held;
        walk_cnt_nx  = walk_cnt;
        flash_cnt_nx = flash_cnt;
        walk_nx      = 1'b0;
        dont_walk_nx = 1'b1;
        countdown_nx = 8'd0;
        abort_nx     = 1'b0;

        unique case (state)
            PED_IDLE: begin
                if (btn) state_nx = green_rise ? PED_WALK : PED_ARMED;
            end
            PED_ARMED: begin
                if (green_rise) state_nx = PED_WALK;
            end
            PED_WALK: begin
                if (!green) begin
                    abort_nx = 1'b1;
                    state_nx = req_held ? PED_ARMED : PED_IDLE;
                end else if (walk_cnt == 8'd0) begin
                    state_nx = PED_CLEAR;
                end else begin
                    walk_cnt_nx = walk_cnt - 8'd1;
                end
            end
            PED_CLEAR: begin
                if (!green) begin
                    abort_nx = 1'b1;
                    state_nx = req_held ? PED_ARMED : PED_IDLE;
                end else if (countdown <= 8'd1) begin
                    state_nx = req_held ? PED_ARMED : PED_IDLE;
                end
            end
            default: state_nx = PED_IDLE;
        endcase

        // A grant consumes the request; presses from here on wait for the next green.
        if (state_nx == PED_WALK && state != PED_WALK) begin
            walk_cnt_nx = WALK_LOAD;
            req_nx      = 1'b0;
        end

        // Outputs are computed for the state being entered so they register with it.
        if (state_nx == PED_WALK) begin
            walk_nx      = 1'b1;
            dont_walk_nx = 1'b0;
        end else if (state_nx == PED_CLEAR) begin
            if (state != PED_CLEAR) begin
                countdown_nx = CLEAR_LOAD;
                flash_cnt_nx = FLASH_LOAD;
                dont_walk_nx = 1'b1;
            end else begin
                countdown_nx = (countdown != 8'd0) ? countdown - 8'd1 : 8'd0;
                if (flash_cnt == '0) begin
                    dont_walk_nx = ~dont_walk;
                    flash_cnt_nx = FLASH_LOAD;
                end else begin
                    dont_walk_nx = dont_walk;
                    flash_cnt_nx = flash_cnt - FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state      <= PED_IDLE;
            prev_green <= 1'b1;
            req        <= 1'b0;
            walk_cnt   <= 8'd0;
            flash_cnt  <= '0;
            walk       <= 1'b0;
            dont_walk  <= 1'b1;
            countdown  <= 8'd0;
            abort      <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_green <= green;
            req        <= req_nx;
            walk_cnt   <= walk_cnt_nx;
            flash_cnt  <= flash_cnt_nx;
            walk       <= walk_nx;
            dont_walk  <= dont_walk_nx;
            countdown  <= countdown_nx;
            abort      <= abort_nx;
        end
    end

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian heads for the NS and EW crosswalks, each tied to its parallel vehicle light.
module ped_signal_controller
    import traffic_pkg::*;
#(
    parameter int WALK_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 6,
    parameter int FLASH_DIV    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    input  logic       ped_btn_ns,
    input  logic       ped_btn_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       dont_walk_ns,
    output logic       dont_walk_ew,
    output logic [7:0] countdown_ns,
    output logic [7:0] countdown_ew,
    output logic       ped_abort
);

    logic abort_ns, abort_ew;

    ped_channel #(
        .WALK_CYCLES (WALK_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .FLASH_DIV   (FLASH_DIV)
    ) u_ns (
        .clk      (clk),
        .reset    (reset),
        .light    (ns_light),
        .btn      (ped_btn_ns),
        .walk     (walk_ns),
        .dont_walk(dont_walk_ns),
        .countdown(countdown_ns),
        .abort    (abort_ns)
    );

    ped_channel #(
        .WALK_CYCLES (WALK_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .FLASH_DIV   (FLASH_DIV)
    ) u_ew (
        .clk      (clk),
        .reset    (reset),
        .light    (ew_light),
        .btn      (ped_btn_ew),
        .walk     (walk_ew),
        .dont_walk(dont_walk_ew),
        .countdown(countdown_ew),
        .abort    (abort_ew)
    );

    // Both sources are flop outputs, so the merged pulse stays one clean cycle wide.
    assign ped_abort = abort_ns | abort_ew;

endmodule
